// File: rtl/cic_interp.sv
// cic_interp: Q-stage CIC interpolator with runtime factor R, bypass path and saturating output.
// Optional macro CIC_INTERP_GAIN_COMP_EN normalises the DC gain by shifting (Q-1)*log2(R) bits.
module cic_interp #(
    parameter int DATA_WIDTH        = 16,
    parameter int DATA_FRAC         = 15,
    parameter int Q                 = 1,
    parameter int N                 = 1,
    parameter int MAX_INTERP_FACTOR = 16,
    parameter int ACC_WIDTH         = DATA_WIDTH + Q * $clog2(N * MAX_INTERP_FACTOR)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                valid_in,
    output logic                                ready_in,
    input  logic                                bypass,
    input  logic [$clog2(MAX_INTERP_FACTOR):0]  interp_factor,
    input  logic                                out_tick,
    input  logic signed [DATA_WIDTH-1:0]        cic_in,
    output logic signed [DATA_WIDTH-1:0]        cic_out,
    output logic                                valid_out,
    output logic                                overflow,
    output logic                                underflow
);

    localparam int ACC_FRAC = DATA_FRAC;
    localparam int RND_SH   = ACC_FRAC - DATA_FRAC;
    localparam int RW       = $clog2(MAX_INTERP_FACTOR) + 1;
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t                       state_q, state_d;
    logic [RW-1:0]                phase_q, phase_d;
    logic [RW-1:0]                r_q, r_d;
    logic signed [ACC_WIDTH-1:0]  dly_q   [Q][N];
    logic signed [ACC_WIDTH-1:0]  dly_d   [Q][N];
    logic signed [ACC_WIDTH-1:0]  integ_q [Q];
    logic signed [ACC_WIDTH-1:0]  integ_d [Q];
    logic signed [ACC_WIDTH-1:0]  comb_q, comb_d;
    logic signed [DATA_WIDTH-1:0] cic_out_q, cic_out_d;
    logic                         valid_out_q, valid_out_d;
    logic                         overflow_q, overflow_d;
    logic                         underflow_q, underflow_d;

    logic                         last, accept;
    logic signed [ACC_WIDTH-1:0]  c_x, c_y, i_x, i_s;

    function automatic logic [RW-1:0] clamp_r(input logic [RW-1:0] f);
        logic [RW-1:0] r;
        r = f;
        if (f == '0)
            r = RW'(1);
        else if (f > RW'(MAX_INTERP_FACTOR))
            r = RW'(MAX_INTERP_FACTOR);
        return r;
    endfunction

`ifdef CIC_INTERP_GAIN_COMP_EN
    function automatic int log2_r(input logic [RW-1:0] r);
        int l;
        l = 0;
        for (int i = 0; i < RW; i++)
            if (r[i]) l = i;
        return l;
    endfunction
`endif

    function automatic logic signed [ACC_WIDTH:0] round_half_up(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH:0] ext, half;
        half = (ACC_WIDTH+1)'((1 << RND_SH) >> 1);
        ext  = {a[ACC_WIDTH-1], a};
        ext  = ext + half;
        return ext >>> RND_SH;
    endfunction

    // Returns {overflow, underflow, sample}.
    function automatic logic [DATA_WIDTH+1:0] saturate(input logic signed [ACC_WIDTH:0] v);
        logic [DATA_WIDTH+1:0] r;
        if (v > SAT_MAX)
            r = {2'b10, SAT_MAX[DATA_WIDTH-1:0]};
        else if (v < SAT_MIN)
            r = {2'b01, SAT_MIN[DATA_WIDTH-1:0]};
        else
            r = {2'b00, v[DATA_WIDTH-1:0]};
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        r_d         = r_q;
        dly_d       = dly_q;
        integ_d     = integ_q;
        comb_d      = comb_q;
        cic_out_d   = cic_out_q;
        valid_out_d = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        c_x         = '0;
        c_y         = '0;
        i_x         = '0;
        i_s         = '0;

        last     = (phase_q == r_q - RW'(1));
        ready_in = bypass || (state_q == IDLE) || (out_tick && last);
        accept   = valid_in && ready_in;

        if (bypass) begin
            state_d     = IDLE;
            phase_d     = '0;
            comb_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            for (int k = 0; k < Q; k++) begin
                integ_d[k] = '0;
                for (int j = 0; j < N; j++)
                    dly_d[k][j] = '0;
            end
            if (valid_in) begin
                cic_out_d   = cic_in;
                valid_out_d = 1'b1;
            end
        end else begin
            if (state_q == RUN && out_tick) begin
                // Zero-stuffing: only the first phase of a sample feeds the comb result in.
                i_x = (phase_q == '0) ? comb_q : '0;
                for (int k = 0; k < Q; k++) begin
                    integ_d[k] = integ_q[k] + i_x;
                    i_x        = integ_d[k];
                end
`ifdef CIC_INTERP_GAIN_COMP_EN
                i_s = i_x >>> ((Q - 1) * log2_r(r_q));
`else
                i_s = i_x;
`endif
                {overflow_d, underflow_d, cic_out_d} = saturate(round_half_up(i_s));
                valid_out_d = 1'b1;
                if (last) begin
                    state_d = IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + RW'(1);
                end
            end
            if (accept) begin
                c_x = {{(ACC_WIDTH-DATA_WIDTH){cic_in[DATA_WIDTH-1]}}, cic_in};
                for (int k = 0; k < Q; k++) begin
                    c_y         = c_x - dly_q[k][N-1];
                    dly_d[k][0] = c_x;
                    for (int j = 1; j < N; j++)
                        dly_d[k][j] = dly_q[k][j-1];
                    c_x = c_y;
                end
                comb_d  = c_x;
                phase_d = '0;
                r_d     = clamp_r(interp_factor);
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            r_q         <= RW'(1);
            comb_q      <= '0;
            cic_out_q   <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int k = 0; k < Q; k++) begin
                integ_q[k] <= '0;
                for (int j = 0; j < N; j++)
                    dly_q[k][j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            r_q         <= r_d;
            comb_q      <= comb_d;
            cic_out_q   <= cic_out_d;
            valid_out_q <= valid_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            integ_q     <= integ_d;
            dly_q       <= dly_d;
        end
    end

    assign cic_out   = cic_out_q;
    assign valid_out = valid_out_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_cic_interp.sv
// Bench for cic_interp: Q=1 and Q=2 instances share stimulus and are compared every cycle
// against a zero-stuffed boxcar-cascade model of the interpolator.
module tb_cic_interp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid_in = 1'b0;
    logic        bypass = 1'b0;
    logic        out_tick = 1'b0;
    logic [4:0]  interp_factor = 5'd1;
    logic [15:0] cic_in = '0;

    logic        ready1, ready2, vout1, vout2, ov1, un1, ov2, un2;
    logic [15:0] out1, out2;

    always #5 clk = ~clk;

    cic_interp #(.Q(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready1),
        .bypass(bypass), .interp_factor(interp_factor), .out_tick(out_tick),
        .cic_in(cic_in), .cic_out(out1), .valid_out(vout1),
        .overflow(ov1), .underflow(un1)
    );

    cic_interp #(.Q(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready2),
        .bypass(bypass), .interp_factor(interp_factor), .out_tick(out_tick),
        .cic_in(cic_in), .cic_out(out2), .valid_out(vout2),
        .overflow(ov2), .underflow(un2)
    );

    int n_chk = 0;
    int n_err = 0;
    int pulses = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: remaining ticks of the current sample, the high-rate zero-stuffed input
    int          m_rem = 0;
    int          m_r = 1;
    longint      m_cur = 0;
    logic        m_acc = 1'b0;
    longint      u[$];
    logic [15:0] e_out [2];
    logic        e_ov [2];
    logic        e_un [2];
    logic        e_vout = 1'b0;

    function automatic int clamp_f(input int f);
        if (f == 0) return 1;
        if (f > 16) return 16;
        return f;
    endfunction

    // Output of Q boxcars of length R over the zero-stuffed stream; Q=2 is a triangle kernel.
    task automatic eval(input int q, output logic [15:0] o, output logic ov, output logic un);
        longint y;
        int     L;
        int     taps;
        y = 0;
        L = m_r;
        taps = (q == 1) ? L : 2 * L - 1;
        for (int j = 0; j < taps; j++) begin
            int     idx;
            longint w;
            idx = u.size() - 1 - j;
            if (idx >= 0) begin
                w = (q == 1) ? 1 : ((j + 1 < 2 * L - 1 - j) ? j + 1 : 2 * L - 1 - j);
                y += w * u[idx];
            end
        end
`ifdef CIC_INTERP_GAIN_COMP_EN
        y = y >>> ((q - 1) * $clog2(L));
`endif
        ov = 1'b0;
        un = 1'b0;
        if (y > 32767) begin
            o = 16'h7FFF;
            ov = 1'b1;
        end else if (y < -32768) begin
            o = 16'h8000;
            un = 1'b1;
        end else begin
            o = y[15:0];
        end
    endtask

    task automatic model_step(input logic vi, input logic tk, input logic [15:0] din,
                              input int ifac, output logic rdy);
        e_vout = 1'b0;
        if (bypass) begin
            rdy = 1'b1;
            m_acc = 1'b0;
            m_rem = 0;
            u.delete();
            for (int q = 0; q < 2; q++) begin
                e_ov[q] = 1'b0;
                e_un[q] = 1'b0;
                if (vi) e_out[q] = din;
            end
            e_vout = vi;
        end else begin
            rdy = (m_rem == 0) || (tk && m_rem == 1);
            m_acc = vi && rdy;
            if (m_rem > 0 && tk) begin
                u.push_back((m_rem == m_r) ? m_cur : 64'sd0);
                for (int q = 0; q < 2; q++)
                    eval(q + 1, e_out[q], e_ov[q], e_un[q]);
                e_vout = 1'b1;
                m_rem--;
            end
            if (m_acc) begin
                m_cur = $signed(din);
                m_r = clamp_f(ifac);
                m_rem = m_r;
            end
        end
    endtask

    task automatic check_outputs();
        chk("vout1", vout1, e_vout);
        chk("vout2", vout2, e_vout);
        chk("out1", out1, e_out[0]);
        chk("out2", out2, e_out[1]);
        chk("ovf1", ov1, e_ov[0]);
        chk("unf1", un1, e_un[0]);
        chk("ovf2", ov2, e_ov[1]);
        chk("unf2", un2, e_un[1]);
    endtask

    // One clock: drive at the negedge, check ready mid-low-phase, check outputs after posedge.
    task automatic step(input logic vi, input logic tk, input logic [15:0] din);
        logic rdy;
        valid_in = vi;
        out_tick = tk;
        cic_in = din;
        #1;
        model_step(vi, tk, din, int'(interp_factor), rdy);
        chk("ready1", ready1, rdy);
        chk("ready2", ready2, rdy);
        @(posedge clk);
        #1;
        check_outputs();
        if (vout1) pulses++;
        @(negedge clk);
    endtask

    task automatic feed(input logic [15:0] din, input int tick_pct);
        int guard;
        guard = 0;
        do begin
            step(1'b1, ($urandom_range(99) < tick_pct) ? 1'b1 : 1'b0, din);
            guard++;
        end while (!m_acc && guard < 100);
        chk("feed_accept", m_acc, 1'b1);
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0, 1'b1, 16'h0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        m_rem = 0;
        m_r = 1;
        m_cur = 0;
        m_acc = 1'b0;
        u.delete();
        e_vout = 1'b0;
        for (int q = 0; q < 2; q++) begin
            e_out[q] = '0;
            e_ov[q] = 1'b0;
            e_un[q] = 1'b0;
        end
        check_outputs();
        valid_in = 1'b0;
        out_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst1", ready1, 1'b1);
        chk("ready_after_rst2", ready2, 1'b1);
    endtask

    int rlist [8] = '{0, 1, 2, 4, 8, 16, 20, 31};

    initial begin
        @(negedge clk);
        do_reset();

        // Two back-to-back samples at R=4 with a tick every cycle
        interp_factor = 5'd4;
        pulses = 0;
        feed(16'h2000, 100);
        feed(16'h4000, 100);
        drain(4);
        chk("r4_pulses", pulses, 8);
        chk("r4_last_out1", out1, 16'h4000);

        // Constant full-scale inputs through the Q=2 instance
        do_reset();
        interp_factor = 5'd4;
        repeat (6) feed(16'h7FFF, 100);
        drain(4);
`ifdef CIC_INTERP_GAIN_COMP_EN
        chk("pos_fs_out2", {ov2, out2}, {1'b0, 16'h7FFF});
`else
        chk("pos_fs_out2", {ov2, out2}, {1'b1, 16'h7FFF});
`endif
        do_reset();
        interp_factor = 5'd4;
        repeat (6) feed(16'h8000, 100);
        drain(4);
`ifdef CIC_INTERP_GAIN_COMP_EN
        chk("neg_fs_out2", {un2, out2}, {1'b0, 16'h8000});
`else
        chk("neg_fs_out2", {un2, out2}, {1'b1, 16'h8000});
`endif
        do_reset();
        interp_factor = 5'd4;
        repeat (6) feed(16'h4000, 100);
        drain(4);
`ifdef CIC_INTERP_GAIN_COMP_EN
        chk("half_fs_out2", {ov2, out2}, {1'b0, 16'h4000});
`else
        chk("half_fs_out2", {ov2, out2}, {1'b1, 16'h7FFF});
`endif

        // Factor change while running only applies from the next accept
        do_reset();
        interp_factor = 5'd8;
        pulses = 0;
        feed(16'h1111, 100);
        interp_factor = 5'd2;
        drain(12);
        chk("latched_r_pulses", pulses, 8);

        // Bypass, both standalone and interrupting a run
        do_reset();
        bypass = 1'b1;
        step(1'b1, 1'b0, 16'h1234);
        chk("bypass_out1", out1, 16'h1234);
        chk("bypass_vout2", vout2, 1'b1);
        bypass = 1'b0;
        interp_factor = 5'd4;
        feed(16'h1000, 100);
        step(1'b0, 1'b1, 16'h0);
        bypass = 1'b1;
        step(1'b0, 1'b1, 16'h0);
        bypass = 1'b0;
        feed(16'h0800, 100);
        feed(16'hF000, 100);
        drain(6);

        // Reset in the middle of an R=8 sample
        do_reset();
        interp_factor = 5'd8;
        feed(16'h3000, 100);
        step(1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b1, 16'h0);
        chk("pre_rst_vout1", vout1, 1'b1);
        pulses = 0;
        do_reset();
        drain(10);
        chk("post_rst_pulses", pulses, 0);

        // Randomised segments over legal and out-of-range factors
        for (int s = 0; s < 8; s++) begin
            do_reset();
            interp_factor = 5'(rlist[s]);
            for (int i = 0; i < 12; i++) begin
                feed(16'($urandom), 70);
                if ($urandom_range(3) == 0)
                    repeat ($urandom_range(1, 6)) step(1'b0, $urandom_range(1) ? 1'b1 : 1'b0, 16'($urandom));
            end
            drain(36);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
